// File: rtl/rom_angle_pkg.sv
// Shared definitions for the streaming angle-constant ROM: FSM state type,
// the fixed angle table contents and the modular address-step helper.
package rom_angle_pkg;

  localparam int ROM_DEPTH = 20;
  localparam int ROM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ROM_WIDTH-1:0] ANGLE_ROM_INIT [ROM_DEPTH] = '{
    16'h1fdf, 16'h1bff, 16'h0aff, 16'h02df, 16'h0fcf,
    16'h0b4f, 16'h0fff, 16'h0fdf, 16'hf3df, 16'h0bff,
    16'hf2ff, 16'hf2cf, 16'h1acf, 16'h1aff, 16'hf2df,
    16'h12df, 16'hff4f, 16'h1fcf, 16'hf3cf, 16'h1b4f
  };

  // addr + stride modulo depth; both operands are assumed < depth, so one
  // conditional subtraction suffices. The sum is one bit wider than the
  // operands so it cannot overflow.
  function automatic logic [31:0] wrap_add(input logic [31:0] addr,
                                           input logic [31:0] stride,
                                           input logic [31:0] depth);
    logic [32:0] sum;
    sum = {1'b0, addr} + {1'b0, stride};
    if (sum >= {1'b0, depth}) begin
      sum = sum - {1'b0, depth};
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/rom_out_fifo2.sv
// Two-entry valid/ready FIFO behind the ROM output register. Overflow is
// prevented upstream by the read-issue credit, so pushes are unconditional.
// dout reads as zero whenever the FIFO is empty.
module rom_out_fifo2 #(
  parameter int WIDTH = 16
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign push      = in_valid;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking; simultaneous push and pop keeps count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage write; contents need no reset because out_valid gates them.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/rams_sp_rom_angle_stream.sv
// Streaming angle-constant ROM: a (base, len, stride) command drives an
// address generator that reads a block ROM and streams words out through a
// 2-entry valid/ready FIFO, one word per cycle when the consumer keeps up.
module rams_sp_rom_angle_stream
  import rom_angle_pkg::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 20,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int LEN_W     = 8
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base,
  input  logic [LEN_W-1:0]     len,
  input  logic [ADDR_W-1:0]    stride,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  logic [MEM_WIDTH-1:0] rom [MEM_DEPTH];

  state_t               state;
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    stride_q;
  logic [ADDR_W-1:0]    addr_next;
  logic [LEN_W-1:0]     remaining;
  logic                 inflight;
  logic [MEM_WIDTH-1:0] rom_q;
  logic [1:0]           fifo_count;
  logic [2:0]           occ;
  logic                 pop;
  logic                 rd_en;
  logic                 args_bad;
  logic                 accept;
  logic                 drain_fin;

  for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_rom
    if (i < ROM_DEPTH) begin : g_init
      assign rom[i] = MEM_WIDTH'(ANGLE_ROM_INIT[i]);
    end else begin : g_zero
      assign rom[i] = '0;
    end
  end

  assign args_bad  = (32'(base) >= 32'(MEM_DEPTH)) || (32'(stride) >= 32'(MEM_DEPTH));
  assign accept    = (state == ST_IDLE) && start && !args_bad;
  assign addr_next = ADDR_W'(wrap_add(32'(addr), 32'(stride_q), 32'(MEM_DEPTH)));
  assign busy      = (state != ST_IDLE);
  assign pop       = dout_valid && dout_ready;

  // Occupancy the FIFO will hold after this edge, counting the read in flight
  // and the slot freed by a pop this cycle; crediting the pop is what allows
  // back-to-back reads at full throughput.
  assign occ       = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign rd_en     = (state == ST_RUN) && (occ < 3'd2);
  assign drain_fin = !inflight && (occ == 3'd0);

  // Control FSM: command acceptance, burst counting, completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (args_bad) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              if (len == '0) begin
                done <= 1'b1;
              end else begin
                remaining <= len;
                state     <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_fin) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address generator: load base on acceptance, step by stride per read.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr     <= base;
      stride_q <= stride;
    end else if (rd_en) begin
      addr <= addr_next;
    end
  end

  // Block-ROM style synchronous read with a one-cycle latency.
  always_ff @(posedge clock) begin
    if (rd_en) rom_q <= rom[addr];
  end

  rom_out_fifo2 #(
    .WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_data   (rom_q),
    .in_valid  (inflight),
    .out_data  (dout),
    .out_valid (dout_valid),
    .out_ready (dout_ready),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_rams_sp_rom_angle_stream.sv
// Bench for the streaming angle ROM: directed bursts push their expected
// words into a queue, an independent monitor pops and compares on each
// output handshake and also polices stall stability and done timing.
module tb_rams_sp_rom_angle_stream;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  base;
  logic [7:0]  len;
  logic [4:0]  stride;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          hs_count = 0;
  int          done_count = 0;
  int          exp_dones = 0;
  bit          adj_check = 1'b1;
  logic [15:0] exp_q [$];
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  rams_sp_rom_angle_stream dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .len        (len),
    .stride     (stride),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each handshake against the scoreboard queue.
  initial begin : monitor
    bit          stall_pending;
    logic [15:0] stall_word;
    logic [15:0] e;
    stall_pending = 1'b0;
    stall_word    = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending) begin
          chk("stall_valid_hold", 32'(dout_valid), 32'd1);
          chk("stall_data_hold", 32'(dout), 32'(stall_word));
        end
        stall_pending = dout_valid && !dout_ready;
        stall_word    = dout;
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h, expected no word", dout);
          end else begin
            e = exp_q.pop_front();
            chk("dout", 32'(dout), 32'(e));
          end
          hs_count++;
          last_hs = cyc;
        end
        if (done) begin
          done_count++;
          chk("done_busy_low", 32'(busy), 32'd0);
          chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
          if (adj_check) chk("done_after_last_hs", 32'(cyc - last_hs), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] b, input logic [7:0] l, input logic [4:0] s);
    base   = b;
    len    = l;
    stride = s;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        if (toggle) dout_ready = pat[k % 6];
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 200 cycles");
    end
    @(posedge clock);
    #1;
    dout_ready = 1'b1;
  endtask

  initial begin : stimulus
    int hs0;
    bit reached;
    reset = 1'b0; start = 1'b0; base = '0; len = '0; stride = '0; dout_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Plain burst with latency check
    exp_q.push_back(16'h1fdf); exp_q.push_back(16'h1bff);
    exp_q.push_back(16'h0aff); exp_q.push_back(16'h02df);
    exp_dones++;
    issue(5'd0, 8'd4, 5'd1);
    @(negedge clock); chk("lat_cycle0_valid", 32'(dout_valid), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clock); chk("lat_cycle1_valid", 32'(dout_valid), 32'd0);
    @(negedge clock); chk("lat_cycle2_valid", 32'(dout_valid), 32'd1);
    wait_done(1'b0);

    // Wrap 19 -> 0
    exp_q.push_back(16'hf3cf); exp_q.push_back(16'h1b4f);
    exp_q.push_back(16'h1fdf); exp_q.push_back(16'h1bff);
    exp_dones++;
    issue(5'd18, 8'd4, 5'd1);
    wait_done(1'b0);

    // Stride 7 with wrap; bad start while busy must be ignored
    exp_q.push_back(16'h12df); exp_q.push_back(16'h0aff); exp_q.push_back(16'h0bff);
    exp_dones++;
    issue(5'd15, 8'd3, 5'd7);
    base  = 5'd20;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock); chk("busy_start_ignored_err", 32'(err), 32'd0);
    wait_done(1'b0);

    // Backpressure with toggling ready
    exp_q.push_back(16'h1fdf); exp_q.push_back(16'h1bff); exp_q.push_back(16'h0aff);
    exp_q.push_back(16'h02df); exp_q.push_back(16'h0fcf); exp_q.push_back(16'h0b4f);
    exp_dones++;
    issue(5'd0, 8'd6, 5'd1);
    wait_done(1'b1);

    // Rejected base, then a good command clears err
    issue(5'd20, 8'd1, 5'd1);
    @(negedge clock);
    chk("bad_base_err", 32'(err), 32'd1);
    chk("bad_base_busy", 32'(busy), 32'd0);
    chk("bad_base_valid", 32'(dout_valid), 32'd0);
    @(posedge clock); #1;
    exp_q.push_back(16'h0b4f);
    exp_dones++;
    issue(5'd5, 8'd1, 5'd1);
    @(negedge clock); chk("err_cleared", 32'(err), 32'd0);
    wait_done(1'b0);

    // Rejected stride, then zero-length command
    issue(5'd0, 8'd1, 5'd20);
    @(negedge clock);
    chk("bad_stride_err", 32'(err), 32'd1);
    chk("bad_stride_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    adj_check = 1'b0;
    exp_dones++;
    issue(5'd3, 8'd0, 5'd2);
    @(negedge clock);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_err_cleared", 32'(err), 32'd0);
    @(posedge clock); #1;
    @(negedge clock); chk("len0_done_one_cycle", 32'(done), 32'd0);
    @(posedge clock); #1;
    adj_check = 1'b1;

    // Reset mid-burst abandons it
    exp_q.push_back(16'h1fdf); exp_q.push_back(16'h1bff); exp_q.push_back(16'h0aff);
    exp_q.push_back(16'h02df); exp_q.push_back(16'h0fcf); exp_q.push_back(16'h0b4f);
    exp_q.push_back(16'h0fff); exp_q.push_back(16'h0fdf);
    hs0 = hs_count;
    issue(5'd0, 8'd8, 5'd1);
    reached = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (hs_count >= hs0 + 2) begin
        reached = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    chk("mid_burst_two_words", 32'(reached), 32'd1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Fresh burst after reset
    exp_q.push_back(16'h1acf); exp_q.push_back(16'h1aff);
    exp_dones++;
    issue(5'd12, 8'd2, 5'd1);
    wait_done(1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pulse_count", 32'(done_count), 32'(exp_dones));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
